// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared types for the iterative ALU: operation codes, FSM states
//            and default widths.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DEFAULT_WIDTH        = 32;
  localparam int DEFAULT_CONTROL_BITS = 4;

  // Operation codes as produced by the ALU control decoder.
  // Codes 10-14 are unassigned; 15 is what the decoder emits by default.
  typedef enum logic [3:0] {
    ALU_ADD     = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_AND     = 4'd2,
    ALU_OR      = 4'd3,
    ALU_SLL     = 4'd4,
    ALU_SLT     = 4'd5,
    ALU_SLTU    = 4'd6,
    ALU_XOR     = 4'd7,
    ALU_SRL     = 4'd8,
    ALU_SRA     = 4'd9,
    ALU_ILLEGAL = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Brief    : Single-cycle combinational ALU operations. Shift codes return 0
//            (the shifter lives in the parent) and are flagged legal;
//            undefined codes return 0 and raise o_illegal.
// Revision : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int CONTROL_BITS = DEFAULT_CONTROL_BITS
) (
  input  logic [CONTROL_BITS-1:0] i_ctrl,
  input  logic [WIDTH-1:0]        i_a,
  input  logic [WIDTH-1:0]        i_b,
  output logic [WIDTH-1:0]        o_result,
  output logic                    o_illegal
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  // Decode the control code and select the matching single-cycle result.
  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_ctrl)
      CONTROL_BITS'(ALU_ADD):  o_result = i_a + i_b;
      CONTROL_BITS'(ALU_SUB):  o_result = i_a - i_b;
      CONTROL_BITS'(ALU_AND):  o_result = i_a & i_b;
      CONTROL_BITS'(ALU_OR):   o_result = i_a | i_b;
      CONTROL_BITS'(ALU_XOR):  o_result = i_a ^ i_b;
      CONTROL_BITS'(ALU_SLT):  o_result = ($signed(i_a) < $signed(i_b)) ? c_one : '0;
      CONTROL_BITS'(ALU_SLTU): o_result = (i_a < i_b) ? c_one : '0;
      CONTROL_BITS'(ALU_SLL),
      CONTROL_BITS'(ALU_SRL),
      CONTROL_BITS'(ALU_SRA):  o_result = '0;
      default:                 o_illegal = 1'b1;
    endcase
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_iterative.sv
`default_nettype none
// ============================================================================
// Module   : alu_iterative
// Brief    : ALU with valid/ready handshakes. Logic/arithmetic operations
//            complete in one cycle; shifts run one bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int CONTROL_BITS = DEFAULT_CONTROL_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CONTROL_BITS-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]        op_a,
  input  logic [WIDTH-1:0]        op_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        result,
  output logic                    zero,
  output logic                    illegal
);

  alu_state_e              r_state;
  alu_state_e              w_next;
  logic [CONTROL_BITS-1:0] r_ctrl;
  logic [WIDTH-1:0]        r_acc;
  logic [4:0]              r_cnt;
  logic                    r_zero;
  logic                    r_illegal;

  logic [WIDTH-1:0]        w_core_result;
  logic                    w_core_illegal;
  logic [WIDTH-1:0]        w_step;
  logic [4:0]              w_shamt;
  logic                    w_is_shift;
  logic                    w_accept;
  logic                    w_last;

  alu_core #(
    .WIDTH        (WIDTH),
    .CONTROL_BITS (CONTROL_BITS)
  ) u_core (
    .i_ctrl    (alu_ctrl),
    .i_a       (op_a),
    .i_b       (op_b),
    .o_result  (w_core_result),
    .o_illegal (w_core_illegal)
  );

  assign w_shamt    = op_b[4:0];
  assign w_is_shift = (alu_ctrl == CONTROL_BITS'(ALU_SLL)) ||
                      (alu_ctrl == CONTROL_BITS'(ALU_SRL)) ||
                      (alu_ctrl == CONTROL_BITS'(ALU_SRA));
  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_last     = (r_cnt == 5'd1);

  // One-bit shift of the accumulator in the direction of the captured code.
  always_comb begin
    w_step = r_acc;
    case (r_ctrl)
      CONTROL_BITS'(ALU_SLL): w_step = {r_acc[WIDTH-2:0], 1'b0};
      CONTROL_BITS'(ALU_SRL): w_step = {1'b0, r_acc[WIDTH-1:1]};
      CONTROL_BITS'(ALU_SRA): w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default:                w_step = r_acc;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs; no accept in the DONE->IDLE cycle.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = (w_is_shift && (|w_shamt)) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, shift while counting down, hold in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_ctrl    <= alu_ctrl;
      r_illegal <= w_core_illegal;
      if (w_is_shift) begin
        r_acc  <= op_a;
        r_cnt  <= w_shamt;
        r_zero <= (op_a == '0);
      end else begin
        r_acc  <= w_core_result;
        r_cnt  <= '0;
        r_zero <= (w_core_result == '0);
      end
    end else if (r_state == ST_SHIFT) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - 5'd1;
      if (w_last) r_zero <= (w_step == '0);
    end
  end

  assign result  = r_acc;
  assign zero    = r_zero;
  assign illegal = r_illegal;

endmodule : alu_iterative
`default_nettype wire
